max_qos_tracker: RTL and testbench

//  Parametrised outstanding-transaction QoS tracker. Records one QoS per in-flight ID on write, retires
//  it on read, and reports the highest QoS among valid entries. Adds per-level occupancy counters,
//  an outstanding count, full/empty flags, protocol-error pulses and an optional output register.

---
 rtl/max_qos_pkg.sv | 8 +
 rtl/max_qos_penc.sv | 23 ++
 rtl/max_qos_tracker.sv | 118 +++++++++++
 tb/tb_max_qos_tracker.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/max_qos_pkg.sv
// Shared defaults and types for the outstanding-transaction QoS tracker.
// Pure declarations: no logic, no latency, no flow control.
package max_qos_pkg;
  localparam int DEF_NUM_IDS = 16;
  localparam int DEF_QOS_W   = 3;
  localparam int NUM_LVLS    = 2**DEF_QOS_W;
  typedef logic [DEF_QOS_W-1:0] qos_t;
endpackage

// File: rtl/max_qos_penc.sv
// Highest-set-index priority encoder over per-level occupancy flags.
// Purely combinational; no backpressure.
module max_qos_penc
  import max_qos_pkg::*;
#(
  parameter int N     = NUM_LVLS,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     nz,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |nz;
    // Ascending scan so the highest set flag is the last one assigned.
    for (int i = 0; i < N; i++) begin
      if (nz[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/max_qos_tracker.sv
// Per-ID QoS tracker reporting the max QoS among in-flight IDs; state updates on each clk edge,
// max is combinational from state (REG_OUT adds one cycle); always accepts rd/wr, no backpressure.
module max_qos_tracker
  import max_qos_pkg::*;
#(
  parameter int NUM_IDS = DEF_NUM_IDS,
  parameter int ID_W    = $clog2(NUM_IDS),
  parameter int QOS_W   = DEF_QOS_W,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [ID_W-1:0]  wr_id,
  input  logic [QOS_W-1:0] wr_qos,
  input  logic             rd_vld,
  input  logic [ID_W-1:0]  rd_id,
  output logic [QOS_W-1:0] rd_qos,
  output logic [QOS_W-1:0] o_max_qos,
  output logic             o_max_vld,
  output logic [ID_W:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_wr_err,
  output logic             o_rd_err
);

  localparam int LVLS  = 2**QOS_W;
  localparam int CNT_W = ID_W + 1;
  localparam int SUM_W = CNT_W + QOS_W;

  logic [NUM_IDS-1:0] vld;
  logic [QOS_W-1:0]   qos     [NUM_IDS];
  logic [CNT_W-1:0]   lvl_cnt [LVLS];
  logic [CNT_W-1:0]   lvl_nxt [LVLS];
  logic [CNT_W-1:0]   count;
  logic               wr_err, rd_err;
  logic               rd_hit, rd_miss, same_retire, wr_over, wr_alloc;
  logic [LVLS-1:0]    nz;
  logic [QOS_W-1:0]   max_c;
  logic               any_c;
  logic [SUM_W-1:0]   lvl_sum;

  always_comb begin
    rd_hit      = rd_vld & vld[rd_id];
    rd_miss     = rd_vld & ~vld[rd_id];
    same_retire = rd_hit & (rd_id == wr_id);
    wr_over     = wr_vld & vld[wr_id] & ~same_retire;
    wr_alloc    = wr_vld & ~wr_over;
    nz          = '0;
    lvl_sum     = '0;
    // A read of one ID and an overwrite of another may both drain the same level.
    for (int l = 0; l < LVLS; l++) begin
      lvl_nxt[l] = lvl_cnt[l]
                 + CNT_W'(wr_vld  && (wr_qos      == QOS_W'(l)))
                 - CNT_W'(rd_hit  && (qos[rd_id]  == QOS_W'(l)))
                 - CNT_W'(wr_over && (qos[wr_id]  == QOS_W'(l)));
      nz[l]      = (lvl_cnt[l] != '0);
      lvl_sum    = lvl_sum + SUM_W'(lvl_cnt[l]);
    end
  end

  assign rd_qos = vld[rd_id] ? qos[rd_id] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      count  <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
      for (int i = 0; i < NUM_IDS; i++) qos[i] <= '0;
      for (int l = 0; l < LVLS; l++) lvl_cnt[l] <= '0;
    end else begin
      if (rd_hit) vld[rd_id] <= 1'b0;
      if (wr_vld) begin
        vld[wr_id] <= 1'b1;
        qos[wr_id] <= wr_qos;
      end
      for (int l = 0; l < LVLS; l++) lvl_cnt[l] <= lvl_nxt[l];
      count  <= count + CNT_W'(wr_alloc) - CNT_W'(rd_hit);
      wr_err <= wr_over;
      rd_err <= rd_miss;
    end
  end

  max_qos_penc #(.N(LVLS), .IDX_W(QOS_W)) u_penc (
    .nz  (nz),
    .idx (max_c),
    .any (any_c)
  );

  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          o_max_qos <= '0;
          o_max_vld <= 1'b0;
        end else begin
          o_max_qos <= max_c;
          o_max_vld <= any_c;
        end
      end
    end else begin : g_comb_out
      assign o_max_qos = max_c;
      assign o_max_vld = any_c;
    end
  endgenerate

  assign o_count  = count;
  assign o_full   = (count == CNT_W'(NUM_IDS));
  assign o_empty  = (count == '0);
  assign o_wr_err = wr_err;
  assign o_rd_err = rd_err;

  lvl_sum_matches_count: assert property (@(posedge clk) disable iff (rst)
    lvl_sum == SUM_W'(count));

endmodule

// File: tb/tb_max_qos_tracker.sv
// Drives a combinational-output and a registered-output tracker in lockstep and checks both
// against a per-ID reference model (directed scenarios, then randomized traffic with resets).
module tb_max_qos_tracker;
  import max_qos_pkg::*;

  localparam int NUM_IDS = 16;
  localparam int ID_W    = 4;
  localparam int QOS_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_vld, rd_vld;
  logic [ID_W-1:0]  wr_id, rd_id;
  qos_t             wr_qos;

  logic [QOS_W-1:0] a_rd_qos, a_max_qos, b_rd_qos, b_max_qos;
  logic             a_max_vld, a_full, a_empty, a_wr_err, a_rd_err;
  logic             b_max_vld, b_full, b_empty, b_wr_err, b_rd_err;
  logic [ID_W:0]    a_count, b_count;

  max_qos_tracker #(.NUM_IDS(NUM_IDS), .ID_W(ID_W), .QOS_W(QOS_W), .REG_OUT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_id(wr_id), .wr_qos(wr_qos),
    .rd_vld(rd_vld), .rd_id(rd_id), .rd_qos(a_rd_qos), .o_max_qos(a_max_qos),
    .o_max_vld(a_max_vld), .o_count(a_count), .o_full(a_full), .o_empty(a_empty),
    .o_wr_err(a_wr_err), .o_rd_err(a_rd_err)
  );

  max_qos_tracker #(.NUM_IDS(NUM_IDS), .ID_W(ID_W), .QOS_W(QOS_W), .REG_OUT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_id(wr_id), .wr_qos(wr_qos),
    .rd_vld(rd_vld), .rd_id(rd_id), .rd_qos(b_rd_qos), .o_max_qos(b_max_qos),
    .o_max_vld(b_max_vld), .o_count(b_count), .o_full(b_full), .o_empty(b_empty),
    .o_wr_err(b_wr_err), .o_rd_err(b_rd_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit m_vld [NUM_IDS];
  int m_qos [NUM_IDS];
  int prev_max;
  bit prev_any;
  bit e_wr_err, e_rd_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_max();
    int mx = 0;
    for (int i = 0; i < NUM_IDS; i++) if (m_vld[i] && m_qos[i] > mx) mx = m_qos[i];
    return mx;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NUM_IDS; i++) if (m_vld[i]) c++;
    return c;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NUM_IDS; i++) begin
      m_vld[i] = 1'b0;
      m_qos[i] = 0;
    end
    prev_max = 0;
    prev_any = 1'b0;
    e_wr_err = 1'b0;
    e_rd_err = 1'b0;
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, "_max_a"},   32'(a_max_qos), 32'(m_max()));
    chk({ph, "_vld_a"},   32'(a_max_vld), 32'(m_cnt() != 0));
    chk({ph, "_max_b"},   32'(b_max_qos), 32'(prev_max));
    chk({ph, "_vld_b"},   32'(b_max_vld), 32'(prev_any));
    chk({ph, "_count_a"}, 32'(a_count),   32'(m_cnt()));
    chk({ph, "_count_b"}, 32'(b_count),   32'(m_cnt()));
    chk({ph, "_full"},    32'(a_full),    32'(m_cnt() == NUM_IDS));
    chk({ph, "_empty"},   32'(a_empty),   32'(m_cnt() == 0));
    chk({ph, "_wr_err"},  32'(a_wr_err),  32'(e_wr_err));
    chk({ph, "_rd_err"},  32'(a_rd_err),  32'(e_rd_err));
    chk({ph, "_wr_err_b"}, 32'(b_wr_err), 32'(e_wr_err));
    chk({ph, "_rd_err_b"}, 32'(b_rd_err), 32'(e_rd_err));
  endtask

  // One clock of traffic: drive after negedge, check lookup, clock, update model, check at negedge.
  task automatic step(input bit wr, input int wid, input int wq, input bit rd, input int rid,
                      input string ph);
    wr_vld = wr;
    wr_id  = ID_W'(wid);
    wr_qos = QOS_W'(wq);
    rd_vld = rd;
    rd_id  = ID_W'(rid);
    #1;
    chk({ph, "_rd_qos"}, 32'(a_rd_qos), 32'(m_vld[rid] ? m_qos[rid] : 0));
    chk({ph, "_rd_qos_b"}, 32'(b_rd_qos), 32'(m_vld[rid] ? m_qos[rid] : 0));
    e_rd_err = rd && !m_vld[rid];
    e_wr_err = wr && m_vld[wid] && !(rd && rid == wid);
    @(posedge clk);
    prev_max = m_max();
    prev_any = (m_cnt() != 0);
    if (rd && m_vld[rid]) m_vld[rid] = 1'b0;
    if (wr) begin
      m_vld[wid] = 1'b1;
      m_qos[wid] = wq;
    end
    @(negedge clk);
    wr_vld = 1'b0;
    rd_vld = 1'b0;
    check_outputs(ph);
  endtask

  task automatic idle(input string ph);
    step(1'b0, 0, 0, 1'b0, 0, ph);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string ph);
    rst = 1'b1;
    #2;
    m_clear();
    check_outputs(ph);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    wr_vld = 1'b0;
    rd_vld = 1'b0;
    wr_id  = '0;
    rd_id  = '0;
    wr_qos = '0;
    m_clear();
    repeat (2) @(negedge clk);
    check_outputs("rst");
    rst = 1'b0;
    idle("t1_idle");
    idle("t1_idle2");

    step(1'b1, 3, 5, 1'b0, 0, "t2_w3");
    step(1'b1, 7, 2, 1'b0, 0, "t2_w7");
    step(1'b0, 0, 0, 1'b1, 3, "t2_r3");
    idle("t2_idle");
    step(1'b0, 0, 0, 1'b1, 7, "t2_r7");

    step(1'b1, 4, 6, 1'b0, 0, "t3_w4a");
    step(1'b1, 4, 6, 1'b0, 0, "t3_w4b");
    idle("t3_idle");
    step(1'b1, 4, 2, 1'b0, 0, "t3_w4c");
    step(1'b0, 0, 0, 1'b1, 4, "t3_r4");

    step(1'b0, 0, 0, 1'b1, 9, "t4_r9");
    idle("t4_idle");
    step(1'b1, 1, 1, 1'b0, 0, "t4_w1");
    step(1'b1, 1, 7, 1'b1, 1, "t4_rw1");
    step(1'b1, 2, 3, 1'b1, 2, "t4_rw2inv");
    step(1'b0, 0, 0, 1'b1, 1, "t4_r1");
    step(1'b0, 0, 0, 1'b1, 2, "t4_r2");

    for (int i = 0; i < NUM_IDS; i++) step(1'b1, i, i % 8, 1'b0, 0, "t5_fill");
    step(1'b0, 0, 0, 1'b1, 7, "t5_r7");
    step(1'b0, 0, 0, 1'b1, 15, "t5_r15");
    idle("t5_idle");
    for (int i = 0; i < NUM_IDS; i++) step(1'b0, 0, 0, 1'b1, i, "t5_drain");

    for (int i = 0; i < 5; i++) step(1'b1, i + 2, 7 - i, 1'b0, 0, "t6_fill");
    async_reset("t6_rst");
    idle("t6_after");
    step(1'b1, 3, 5, 1'b0, 0, "t6_w3");
    step(1'b1, 7, 2, 1'b0, 0, "t6_w7");
    step(1'b0, 0, 0, 1'b1, 3, "t6_r3");
    idle("t6_idle");

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 99) < 55, int'($urandom_range(0, NUM_IDS - 1)),
             int'($urandom_range(0, 7)), $urandom_range(0, 99) < 45,
             int'($urandom_range(0, NUM_IDS - 1)), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
